// File: rtl/pe_result_drain.sv
// Result drain for the last PE of the systolic MAC chain: buffers whole result
// vectors in a small FIFO and replays them as a lane-by-lane valid/ready stream.
module pe_result_drain #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 6,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] c_in [VECTOR-1:0],
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [REG_WIDTH-1:0] out_data,
    output logic [((VECTOR > 1) ? $clog2(VECTOR) : 1)-1:0] out_lane,
    output logic                 out_last,
    output logic [7:0]           out_vec_id,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int LANE_W = (VECTOR > 1) ? $clog2(VECTOR) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state, state_next;

    logic [REG_WIDTH-1:0] mem      [DEPTH-1:0][VECTOR-1:0];
    logic [REG_WIDTH-1:0] lane_reg [VECTOR-1:0];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic wr_en;
    logic beat;
    logic pop;
    logic lane_inc;
    logic vec_done;

    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign wr_en     = in_valid && in_ready;
    assign out_valid = (state == SEND);
    assign beat      = out_valid && out_ready;
    assign out_data  = lane_reg[out_lane];
    assign out_last  = out_valid && (out_lane == LAST_LANE);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        pop        = 1'b0;
        lane_inc   = 1'b0;
        vec_done   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (beat) begin
                    if (out_lane != LAST_LANE) begin
                        lane_inc = 1'b1;
                    end else begin
                        vec_done = 1'b1;
                        // Back-to-back vectors: reload the lane register on the last beat.
                        if (count != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < VECTOR; l++) begin
                mem[wr_ptr][l] <= c_in[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < VECTOR; l++) begin
                lane_reg[l] <= '0;
            end
            out_lane   <= '0;
            out_vec_id <= '0;
        end else begin
            if (pop) begin
                for (int l = 0; l < VECTOR; l++) begin
                    lane_reg[l] <= mem[rd_ptr][l];
                end
                out_lane <= '0;
            end else if (lane_inc) begin
                out_lane <= out_lane + LANE_W'(1);
            end else if (vec_done) begin
                out_lane <= '0;
            end
            if (vec_done) begin
                out_vec_id <= out_vec_id + 8'd1;
            end
        end
    end

endmodule
